// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
//   Shared definitions for the sequential divider:
//     - DEFAULT_WIDTH : default operand / result width
//     - state_t       : controller state encoding (3 bits)
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    SUB    = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage : seq_divider_pkg

// File: rtl/div_cmp_sub.sv
// -----------------------------------------------------------------------------
// div_cmp_sub
//   Combinational compare-and-subtract step for the divider.
//   Ports:
//     minuend    in  WIDTH  current partial remainder
//     subtrahend in  WIDTH  divisor
//     ge         out 1      minuend >= subtrahend (unsigned)
//     diff       out WIDTH  minuend - subtrahend (only meaningful when ge=1)
// -----------------------------------------------------------------------------
module div_cmp_sub
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             ge,
  output logic [WIDTH-1:0] diff
);

  // Both operands are WIDTH-bit unsigned, so the compare is exact and the
  // difference never wraps whenever ge is set.
  assign ge   = (minuend >= subtrahend);
  assign diff = minuend - subtrahend;

endmodule : div_cmp_sub

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Unsigned divider by repeated subtraction, one subtraction per clock.
//   Operands arrive one after the other on a shared bus: dividend in LOAD_A,
//   divisor in LOAD_B.
//   Ports:
//     clk          in  1      clock, rising edge
//     rst          in  1      asynchronous active-high reset
//     start        in  1      begin a division (honoured in IDLE or DONE only)
//     data_in      in  WIDTH  operand bus
//     quotient     out WIDTH  result quotient, valid while done=1
//     remainder    out WIDTH  result remainder, valid while done=1
//     done         out 1      high exactly while in DONE
//     busy         out 1      high in LOAD_A, LOAD_B, CHECK, SUB
//     div_by_zero  out 1      high in DONE when the divisor was 0
// -----------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] divisor;
  logic             dbz_flag;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_diff;

  div_cmp_sub #(
    .WIDTH(WIDTH)
  ) u_cmp_sub (
    .minuend   (remainder),
    .subtrahend(divisor),
    .ge        (rem_ge),
    .diff      (rem_diff)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD_A;
      LOAD_A:  state_next = LOAD_B;
      LOAD_B:  state_next = CHECK;
      CHECK:   state_next = (divisor == '0) ? DONE : SUB;
      SUB:     if (!rem_ge) state_next = DONE;
      DONE:    if (start) state_next = LOAD_A;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: derived from registered state only, never from inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    done        = (state == DONE);
    busy        = (state == LOAD_A) || (state == LOAD_B) ||
                  (state == CHECK)  || (state == SUB);
    div_by_zero = (state == DONE) && dbz_flag;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. The remainder register doubles as the dividend store.
  // ---------------------------------------------------------------------------
  // NOTE: every datapath register is reset so an aborted division leaves no
  // stale operand or result visible afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      divisor   <= '0;
      dbz_flag  <= 1'b0;
    end else begin
      case (state)
        LOAD_A: remainder <= data_in;
        LOAD_B: begin
          divisor  <= data_in;
          quotient <= '0;
          dbz_flag <= 1'b0;
        end
        CHECK: begin
          if (divisor == '0) begin
            dbz_flag <= 1'b1;
            quotient <= '1;
          end
        end
        SUB: begin
          // Quotient cannot exceed 2^WIDTH-1 (divisor >= 1), so no wrap guard.
          if (rem_ge) begin
            remainder <= rem_diff;
            quotient  <= quotient + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : seq_divider

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 16, data width of operands, quotient and remainder.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE or DONE.
REQ-005 data_in  input  WIDTH  shared operand bus: dividend in LOAD_A, divisor in LOAD_B.
REQ-006 quotient  output  WIDTH  registered quotient; valid while done=1.
REQ-007 remainder  output  WIDTH  registered remainder; valid while done=1.
REQ-008 done  output  1  high exactly while in DONE.
REQ-009 busy  output  1  high in LOAD_A, LOAD_B, CHECK and SUB.
REQ-010 div_by_zero  output  1  high in DONE when the captured divisor was 0; low otherwise.

Function
REQ-011 Algorithm SHALL be unsigned repeated subtraction, one subtraction per clock, the inverse of the team's repeated-addition multiplier.
REQ-012 States SHALL be IDLE, LOAD_A, LOAD_B, CHECK, SUB and DONE.
REQ-013 IDLE: start=1 at an edge -> LOAD_A; otherwise stay in IDLE.
REQ-014 LOAD_A: the edge captures data_in as dividend into the remainder register -> LOAD_B.
REQ-015 LOAD_B: the edge captures data_in as divisor, clears quotient to 0 -> CHECK.
REQ-016 CHECK with divisor=0 -> DONE: div_by_zero=1, quotient=all ones, remainder=dividend.
REQ-017 CHECK with divisor!=0 -> SUB, div_by_zero=0.
REQ-018 SUB, remainder>=divisor: remainder<=remainder-divisor, quotient<=quotient+1, stay in SUB.
REQ-019 SUB, remainder<divisor: -> DONE; quotient and remainder unchanged.
REQ-020 Latency: done SHALL rise Q+4 edges after the edge that samples start (Q = final quotient), or 3 edges after it when the divisor is 0.
REQ-021 Quotient SHALL NOT overflow: the maximum is 2^WIDTH-1 when the divisor is 1. No saturation logic is required.
REQ-022 Comparison and subtraction SHALL be full WIDTH unsigned, with no truncation.
REQ-023 DONE: outputs held stable. start=1 at an edge -> LOAD_A (done falls); otherwise stay in DONE.
REQ-024 start while busy=1 SHALL be ignored; no restart, no result corruption.
REQ-025 data_in SHALL be ignored in every state except LOAD_A and LOAD_B.
REQ-026 Dividend < divisor SHALL give quotient=0, remainder=dividend, with SUB exiting on its first edge.
REQ-027 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 SHALL force IDLE immediately, independent of clk.
REQ-029 rst=1 SHALL clear quotient, remainder, the divisor register, done, busy and div_by_zero to 0.
REQ-030 rst asserted mid-operation (any state) SHALL abort the division. No partial result SHALL be flagged with done.
REQ-031 After rst deasserts, the first start is handled per REQ-013.

Structure
REQ-032 A shared package SHALL hold the state enumeration (3-bit encoding) and the default WIDTH constant.
REQ-033 One sub-module div_cmp_sub SHALL provide the combinational remainder>=divisor flag and the difference.
REQ-034 The controller FSM and the datapath registers SHALL live in seq_divider.

Verification
REQ-035 100 then 7 -> quotient=14, remainder=2, div_by_zero=0, done 18 edges after the start edge.
REQ-036 5 then 9 -> quotient=0, remainder=5, done 4 edges after the start edge.
REQ-037 42 then 0 -> div_by_zero=1, quotient=16'hFFFF, remainder=42, done 3 edges after the start edge.
REQ-038 16'hFFFF then 1 -> quotient=16'hFFFF, remainder=0, done 65539 edges after the start edge.
REQ-039 rst pulsed during SUB of 1000/3 -> all outputs 0 at once, state IDLE. Then 9/3 -> quotient=3, remainder=0.
REQ-040 start pulsed during SUB is ignored (result unchanged). start in DONE -> done falls next edge, new operands are loaded and the new result is correct.
